cla_pipe_adder: RTL
===================

Name: cla_pipe_adder

Overview:
Parametrised, pipelined carry-lookahead adder/subtractor. It is the next generation of the team's 4-bit combinational CLA. The WIDTH-bit operands are split into BLOCK-bit lookahead groups, with one register stage per group. A valid/ready handshake on both sides allows back-to-back streaming under backpressure. It adds subtract mode and a signed-overflow flag.

Parameters:
WIDTH, 16, operand/sum width in bits; must be a multiple of BLOCK and at least BLOCK.
BLOCK, 4, bits per lookahead group; the pipeline has NSTAGE = WIDTH/BLOCK stages.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst  input  1  synchronous, active-high reset.
in_valid  input  1  operand beat is present.
in_ready  output  1  block accepts a beat this cycle.
a  input  WIDTH  operand A, unsigned or two's complement.
b  input  WIDTH  operand B.
cin  input  1  carry-in (add) or borrow-in (subtract).
sub  input  1  0 = A+B+cin; 1 = A-B-cin.
out_valid  output  1  result beat is present.
out_ready  input  1  downstream accepts the result.
s  output  WIDTH  sum/difference.
cout  output  1  carry-out of the MSB; in subtract mode 1 = no borrow.
ovf  output  1  signed overflow.

Behaviour:
- Reset: clk is the only clock; rst is synchronous and active-high. While rst=1 at a rising edge:
  - All stage valid bits clear; all data registers clear.
  - out_valid=0, s=0, cout=0, ovf=0, in_ready=1 the following cycle.
  - Any in-flight beats are discarded; none appear after reset is released.
- Operand conditioning at accept:
  - b_eff = sub ? ~b : b.
  - c0 = cin XOR sub, so subtract computes A + ~B + 1 - cin.
- Stage k (0..NSTAGE-1) holds:
  - the sum bits of groups 0..k-1, already resolved;
  - the unprocessed A/b_eff slices of groups k..NSTAGE-1;
  - a valid bit;
  - the registered carry into group k.
- Per-stage group logic: stage k computes group k with a BLOCK-bit lookahead:
  - p_i = a_i^b_i, g_i = a_i&b_i;
  - c_{i+1} = g_i | p_i&c_i, expanded as lookahead within the group, not as a ripple;
  - group carry-out is registered into the next stage.
- Last stage outputs:
  - s = concatenation of all group sums;
  - cout = carry out of the top group;
  - ovf = carry into MSB XOR carry out of MSB, valid for both add and subtract.
- Latency: a beat accepted at edge T appears with out_valid=1 after edge T+NSTAGE-1 (NSTAGE cycles of register delay counting the input stage). For WIDTH=16, BLOCK=4 that is 4 cycles.
- Advance rule:
  - adv = !out_valid | out_ready.
  - in_ready = adv, combinational, with no dependence on in_valid.
  - When adv=1, every stage loads from its predecessor; stage 0 valid <= in_valid.
  - When adv=0, all stages hold; s/cout/ovf remain stable while out_valid=1 and out_ready=0.
- Bubbles travel through the pipeline and are not compressed. Throughput is 1 beat/cycle when out_ready stays high.
- Output transfer occurs on any edge with out_valid & out_ready. Each accepted input yields exactly one output, in order.
- Simultaneous accept and emit on the same edge is legal and required for full throughput.
- Data registers of invalid stages may hold stale values. s/cout/ovf are don't-care while out_valid=0, except directly after reset (0).
- Widths: no internal width growth; the carry chain is exactly WIDTH+1 bits. WIDTH==BLOCK degenerates to one registered stage.

Test Plan:
- Plain add (WIDTH=16, BLOCK=4): a=0x1234, b=0x4321, cin=0, sub=0 -> 4 cycles later s=0x5555, cout=0, ovf=0.
- Full carry chain through every stage: a=0xFFFF, b=0x0001, cin=0 -> s=0x0000, cout=1, ovf=0. Then a=0x7FFF, b=0x0001 next cycle -> s=0x8000, cout=0, ovf=1, emitted on the following cycle.
- Subtract with borrow:
  - a=0x0005, b=0x0007, sub=1, cin=0 -> s=0xFFFE, cout=0, ovf=0.
  - Same with cin=1 -> s=0xFFFD.
  - a=0x8000, b=0x0001, sub=1 -> s=0x7FFF, ovf=1, cout=1.
- Backpressure: stream 6 back-to-back beats (a=i, b=0x0100, i=1..6); hold out_ready=0 for 3 cycles once the first out_valid rises.
  - in_ready=0 during those cycles.
  - s stays 0x0101.
  - Outputs 0x0101..0x0106 then emerge in order, with no drops or duplicates.
- Reset mid-operation: with 3 beats in flight, assert rst for 1 cycle -> next cycle out_valid=0 and s=0. No stale result appears within NSTAGE+2 cycles of release.
- Parameter sweep: WIDTH=8, BLOCK=4, a=0xFF, b=0x01, cin=1 -> latency 2, s=0x01, cout=1. Also run a random 1000-beat compare against a behavioural A±B model with random out_ready.

Source files
------------

// File: rtl/cla_pipe_adder.sv
// Pipelined carry-lookahead adder/subtractor.
// One BLOCK-bit lookahead group is resolved per register stage.
module cla_pipe_adder #(
    parameter int WIDTH = 16,
    parameter int BLOCK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf
);

    localparam int NSTAGE = WIDTH / BLOCK;

    logic adv;

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    // Group carries as flat sum-of-products, no ripple between bits.
    function automatic logic [BLOCK:0] lookahead(
        input logic [BLOCK-1:0] x,
        input logic [BLOCK-1:0] y,
        input logic             c0
    );
        logic [BLOCK-1:0] p;
        logic [BLOCK-1:0] g;
        logic [BLOCK:0]   c;
        logic             t;
        p    = x ^ y;
        g    = x & y;
        c    = '0;
        c[0] = c0;
        for (int i = 0; i < BLOCK; i++) begin
            t = c0;
            for (int j = 0; j <= i; j++) begin
                t = t & p[j];
            end
            c[i+1] = t;
            for (int j = 0; j <= i; j++) begin
                t = g[j];
                for (int m = j + 1; m <= i; m++) begin
                    t = t & p[m];
                end
                c[i+1] = c[i+1] | t;
            end
        end
        return c;
    endfunction

    // Stage k: acc holds resolved sum bits below group k and raw A above;
    // rb holds only the b_eff slices not yet consumed.
    for (genvar k = 0; k < NSTAGE; k++) begin : st
        localparam int RW = WIDTH - k * BLOCK;

        logic             v;
        logic             c;
        logic [WIDTH-1:0] acc;
        logic [RW-1:0]    rb;
        logic [BLOCK:0]   cc;
        logic [WIDTH-1:0] nacc;

        // Resolve group k and splice its sum into the accumulator.
        always_comb begin
            cc   = lookahead(acc[k*BLOCK +: BLOCK], rb[BLOCK-1:0], c);
            nacc = acc;
            nacc[k*BLOCK +: BLOCK] = acc[k*BLOCK +: BLOCK]
                                   ^ rb[BLOCK-1:0]
                                   ^ cc[BLOCK-1:0];
        end

        if (k == 0) begin : ld
            // Input stage: condition operands for subtract at accept.
            always_ff @(posedge clk) begin
                if (rst) begin
                    v   <= 1'b0;
                    c   <= 1'b0;
                    acc <= '0;
                    rb  <= '0;
                end else if (adv) begin
                    v   <= in_valid;
                    c   <= cin ^ sub;
                    acc <= a;
                    rb  <= sub ? ~b : b;
                end
            end
        end else begin : ld
            // Inner stage: take the predecessor's partial result and carry.
            always_ff @(posedge clk) begin
                if (rst) begin
                    v   <= 1'b0;
                    c   <= 1'b0;
                    acc <= '0;
                    rb  <= '0;
                end else if (adv) begin
                    v   <= st[k-1].v;
                    c   <= st[k-1].cc[BLOCK];
                    acc <= st[k-1].nacc;
                    rb  <= st[k-1].rb[RW+BLOCK-1:BLOCK];
                end
            end
        end
    end

    assign out_valid = st[NSTAGE-1].v;
    assign s         = st[NSTAGE-1].nacc;
    assign cout      = st[NSTAGE-1].cc[BLOCK];
    assign ovf       = st[NSTAGE-1].cc[BLOCK] ^ st[NSTAGE-1].cc[BLOCK-1];

endmodule
